// File: rtl/regfile_onehot_wr.sv
// 32-entry register file whose write port is a one-hot select from a 5-to-32 decoder.
// Two registered read ports with same-edge write bypass, and a sticky multi-hot error flag.
module regfile_onehot_wr #(
  parameter int WIDTH   = 32,
  parameter bit R0_ZERO = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ld,
  input  logic [WIDTH-1:0] pw,
  input  logic [4:0]       ra,
  input  logic [4:0]       rb,
  input  logic             re,
  output logic [WIDTH-1:0] pa,
  output logic [WIDTH-1:0] pb,
  output logic             valid,
  output logic             wr_err,
  output logic [7:0]       wr_cnt
);

  logic [WIDTH-1:0] regs [32];
  logic             multi_hot;
  logic             one_hot;
  logic [31:0]      wr_sel;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  // x & (x-1) clears the lowest set bit, so a non-zero result means two or more bits are set.
  always_comb begin
    multi_hot = (ld & (ld - 32'd1)) != 32'd0;
    one_hot   = (ld != 32'd0) && !multi_hot;
    wr_sel    = one_hot ? ld : 32'd0;
    if (R0_ZERO) wr_sel[0] = 1'b0;
  end

  // Effective read value: a legal write to the same index wins over the stored word.
  always_comb begin
    rd_a = wr_sel[ra] ? pw : regs[ra];
    rd_b = wr_sel[rb] ? pw : regs[rb];
    if (R0_ZERO && ra == 5'd0) rd_a = '0;
    if (R0_ZERO && rb == 5'd0) rd_b = '0;
  end

  // NOTE: the register array is cleared on reset because the block guarantees every
  // entry reads 0 afterwards; this costs a reset net on each flop, so no RAM macro.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      pa     <= '0;
      pb     <= '0;
      valid  <= 1'b0;
      wr_err <= 1'b0;
      wr_cnt <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments keep every read in this block seeing pre-edge state.
      for (int i = 0; i < 32; i++) begin
        if (wr_sel[i]) regs[i] <= pw;
      end
      if (|wr_sel && wr_cnt != 8'hFF) wr_cnt <= wr_cnt + 8'd1;
      if (multi_hot) wr_err <= 1'b1;
      if (re) begin
        pa    <= rd_a;
        pb    <= rd_b;
        valid <= 1'b1;
      end else begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_onehot_wr.sv
// Self-checking bench for regfile_onehot_wr: directed plan steps plus a random phase,
// all compared against an array-based model of the register file rules.
module tb_regfile_onehot_wr;

  logic        clock;
  logic        reset;
  logic [31:0] ld;
  logic [31:0] pw;
  logic [4:0]  ra;
  logic [4:0]  rb;
  logic        re;
  logic [31:0] pa;
  logic [31:0] pb;
  logic        valid;
  logic        wr_err;
  logic [7:0]  wr_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_regs [32];
  logic [31:0] m_pa, m_pb;
  logic        m_valid, m_err;
  int          m_cnt;

  regfile_onehot_wr #(.WIDTH(32), .R0_ZERO(1'b1)) dut (
    .clock (clock),
    .reset (reset),
    .ld    (ld),
    .pw    (pw),
    .ra    (ra),
    .rb    (rb),
    .re    (re),
    .pa    (pa),
    .pb    (pb),
    .valid (valid),
    .wr_err(wr_err),
    .wr_cnt(wr_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Applies the rules for one rising edge using the inputs currently driven.
  task automatic model_edge();
    int n;
    int idx;
    bit legal;
    logic [31:0] va, vb;
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pa = 0; m_pb = 0; m_valid = 0; m_err = 0; m_cnt = 0;
      return;
    end
    n   = $countones(ld);
    idx = -1;
    for (int i = 0; i < 32; i++) if (ld[i]) idx = i;
    legal = (n == 1) && (idx != 0);
    if (n > 1) m_err = 1'b1;
    va = (ra == 0) ? 32'd0 : (legal && idx == int'(ra)) ? pw : m_regs[ra];
    vb = (rb == 0) ? 32'd0 : (legal && idx == int'(rb)) ? pw : m_regs[rb];
    if (legal) begin
      m_regs[idx] = pw;
      if (m_cnt < 255) m_cnt++;
    end
    if (re) begin
      m_pa = va; m_pb = vb; m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] l, input logic [31:0] d,
                      input logic r_en, input logic [4:0] a, input logic [4:0] b,
                      input string tag);
    reset = rst; ld = l; pw = d; re = r_en; ra = a; rb = b;
    @(posedge clock);
    model_edge();
    #1;
    check({tag, ".pa"},     pa,     m_pa);
    check({tag, ".pb"},     pb,     m_pb);
    check({tag, ".valid"},  {31'd0, valid},  {31'd0, m_valid});
    check({tag, ".wr_err"}, {31'd0, wr_err}, {31'd0, m_err});
    check({tag, ".wr_cnt"}, {24'd0, wr_cnt}, m_cnt);
  endtask

  function automatic logic [31:0] rand_onehot();
    return 32'd1 << $urandom_range(31, 0);
  endfunction

  initial begin
    // Reset state
    step(1'b1, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, "reset0");
    check("reset0.cnt_zero", {24'd0, wr_cnt}, 32'd0);

    // Random writes, then reset mid-stream with a write and read at the reset edge
    for (int i = 0; i < 20; i++)
      step(1'b0, rand_onehot(), $urandom, 1'($urandom), 5'($urandom), 5'($urandom), "rw_pre");
    step(1'b1, 32'h0000_0100, 32'hCAFE_F00D, 1'b1, 5'd8, 5'd8, "reset1");
    check("reset1.pa_zero", pa, 32'd0);
    for (int a = 1; a < 32; a++)
      step(1'b0, 32'd0, 32'd0, 1'b1, 5'(a), 5'(32 - a), "post_reset_read");

    // One-hot sweep from a clean state
    step(1'b1, 32'd0, 32'd0, 1'b0, 5'd0, 5'd0, "reset2");
    for (int i = 0; i < 32; i++)
      step(1'b0, 32'd1 << i, 32'hA500_0000 | i, 1'b0, 5'd0, 5'd0, "sweep_wr");
    check("sweep.wr_cnt_31", {24'd0, wr_cnt}, 32'd31);
    for (int i = 0; i < 32; i++)
      step(1'b0, 32'd0, 32'd0, 1'b1, 5'(i), 5'(31 - i), "sweep_rd");
    step(1'b0, 32'd0, 32'd0, 1'b1, 5'd3, 5'd0, "sweep_r0");
    check("sweep.pa_reg3", pa, 32'hA500_0003);
    check("sweep.pb_reg0", pb, 32'd0);

    // Same-edge bypass, including the hardwired-zero register
    step(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 5'd4, 5'd4, "bypass");
    check("bypass.pa", pa, 32'hDEAD_BEEF);
    check("bypass.valid", {31'd0, valid}, 32'd1);
    step(1'b0, 32'h0000_0001, 32'h1234_5678, 1'b1, 5'd0, 5'd4, "bypass_r0");
    check("bypass_r0.pa", pa, 32'd0);

    // Multi-hot write is blocked and flagged
    step(1'b0, 32'h0000_0002, 32'h1111_1111, 1'b0, 5'd0, 5'd0, "pre_r1");
    step(1'b0, 32'h0000_0004, 32'h2222_2222, 1'b0, 5'd0, 5'd0, "pre_r2");
    step(1'b0, 32'h0000_0006, 32'hFFFF_FFFF, 1'b1, 5'd1, 5'd2, "multi");
    check("multi.wr_err", {31'd0, wr_err}, 32'd1);
    check("multi.pa_bypass_blocked", pa, 32'h1111_1111);
    step(1'b0, 32'd0, 32'd0, 1'b1, 5'd1, 5'd2, "multi_rd");
    check("multi.reg1", pa, 32'h1111_1111);
    check("multi.reg2", pb, 32'h2222_2222);
    step(1'b0, 32'h0000_0200, 32'h0BAD_0BAD, 1'b0, 5'd0, 5'd0, "multi_after");
    check("multi.sticky", {31'd0, wr_err}, 32'd1);

    // Hold: re low keeps pa/pb while addresses change
    step(1'b0, 32'h0000_0020, 32'h5555_AAAA, 1'b0, 5'd0, 5'd0, "hold_wr");
    step(1'b0, 32'd0, 32'd0, 1'b1, 5'd5, 5'd5, "hold_rd");
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 32'd0, 32'd0, 1'b0, 5'(k + 9), 5'(k + 1), "hold");
      check("hold.pa_kept", pa, 32'h5555_AAAA);
      check("hold.valid_low", {31'd0, valid}, 32'd0);
    end

    // Saturation of the write counter, then reset clears it
    for (int k = 0; k < 300; k++)
      step(1'b0, 32'h0000_0080, k, 1'b0, 5'd0, 5'd0, "sat");
    check("sat.wr_cnt_255", {24'd0, wr_cnt}, 32'd255);
    step(1'b1, 32'h0000_0080, 32'd1, 1'b1, 5'd7, 5'd7, "sat_reset");
    check("sat_reset.wr_cnt_0", {24'd0, wr_cnt}, 32'd0);

    // Random traffic: mostly one-hot, some idle and multi-hot, rare resets
    for (int k = 0; k < 400; k++) begin
      logic [31:0] l;
      int sel;
      sel = $urandom_range(19, 0);
      if (sel < 14)      l = rand_onehot();
      else if (sel < 17) l = 32'd0;
      else               l = $urandom;
      step(($urandom_range(49, 0) == 0), l, $urandom, 1'($urandom),
           5'($urandom), 5'($urandom), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
